ace_request_engine: RTL

- Sits directly downstream of the cache controller. Converts its single-bit read_req / write_req / invalid_req into multi-beat ACE-style bus transactions toward the interconnect.
- Returns a one-cycle ace_ready when the transaction completes.
- Deserialises read line fills for the cache datapath and serialises dirty-line writebacks from it.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/ace_request_engine_if.sv | 46 ++++
 rtl/ace_line_buffer.sv | 44 ++++
 rtl/ace_request_engine.sv | 121 ++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and ACE encodings for the cache-side request engine.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR_SEND,
    R_RECV,
    AW_SEND,
    W_SEND,
    B_WAIT,
    DONE
  } ace_state_t;

  typedef enum logic [1:0] {
    REQ_READ,
    REQ_WRITE,
    REQ_INV
  } req_kind_t;

  localparam logic [3:0] ARSNOOP_READSHARED  = 4'b0001;
  localparam logic [3:0] ARSNOOP_CLEANUNIQUE = 4'b1011;
  localparam logic [2:0] AWSNOOP_WRITEBACK   = 3'b011;
  localparam logic [1:0] RESP_OKAY           = 2'b00;

  // SLVERR and DECERR both carry bit 1 of the response field.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/ace_request_engine_if.sv
// ACE read/write channel bundle between the request engine (master) and the interconnect.
interface ace_request_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [3:0]            arsnoop;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [3:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  logic                  rack;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsnoop;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic                  wack;

  modport master (
    output araddr, arlen, arsnoop, arvalid, input arready,
    input rdata, rresp, rlast, rvalid, output rready, rack,
    output awaddr, awlen, awsnoop, awvalid, input awready,
    output wdata, wlast, wvalid, input wready,
    input bresp, bvalid, output bready, wack
  );

  modport slave (
    input araddr, arlen, arsnoop, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready, rack,
    input awaddr, awlen, awsnoop, awvalid, output awready,
    input wdata, wlast, wvalid, output wready,
    output bresp, bvalid, input bready, wack
  );
endinterface

// File: rtl/ace_line_buffer.sv
// Cache-line register shared by read fills and writebacks, with its beat counter.
module ace_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [BEATS*DATA_WIDTH-1:0]   load_line,
  input  logic                          fill_we,
  input  logic [DATA_WIDTH-1:0]         fill_data,
  input  logic                          clr,
  input  logic                          adv,
  output logic [BEATS*DATA_WIDTH-1:0]   line,
  output logic [DATA_WIDTH-1:0]         beat_data,
  output logic [$clog2(BEATS)-1:0]      beat,
  output logic                          last_beat
);
  localparam int CNT_W = $clog2(BEATS);

  logic [BEATS-1:0][DATA_WIDTH-1:0] line_q;
  logic [CNT_W-1:0]                 beat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
      beat_q <= '0;
    end else begin
      if (load)
        line_q <= load_line;
      else if (fill_we)
        line_q[beat_q] <= fill_data;
      if (clr)
        beat_q <= '0;
      else if (adv)
        beat_q <= beat_q + 1'b1;
    end
  end

  assign line      = line_q;
  assign beat_data = line_q[beat_q];
  assign beat      = beat_q;
  assign last_beat = (beat_q == CNT_W'(BEATS - 1));
endmodule

// File: rtl/ace_request_engine.sv
// Turns cache-controller read/write/invalidate requests into multi-beat ACE transactions.
//   state   | meaning
//   IDLE    | sample requests (write > invalidate > read)
//   AR_SEND | read address valid, waiting for arready
//   R_RECV  | collecting read beats (one beat for invalidate)
//   AW_SEND | writeback address valid, waiting for awready
//   W_SEND  | serialising the victim line
//   B_WAIT  | waiting for write response
//   DONE    | one-cycle completion pulse
module ace_request_engine
  import cache_pkg::*;
#(
  parameter int  ADDR_WIDTH = 32,
  parameter int  DATA_WIDTH = 32,
  parameter int  BEATS      = 4,
  localparam int LINE_WIDTH = DATA_WIDTH * BEATS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic                  invalid_req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] wb_line,
  output logic                  ace_ready,
  output logic [LINE_WIDTH-1:0] fill_line,
  output logic                  fill_shared,
  output logic                  resp_err,
  ace_request_engine_if.master  bus
);
  ace_state_t            state_q, state_d;
  req_kind_t             kind_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  err_q, shared_q;

  logic [$clog2(BEATS)-1:0] beat;
  logic                     last_beat;
  logic [DATA_WIDTH-1:0]    beat_data;
  logic                     accept, r_hs, w_hs, final_beat;

  assign accept     = (state_q == IDLE) && (write_req || invalid_req || read_req);
  assign r_hs       = (state_q == R_RECV) && bus.rvalid;
  assign w_hs       = (state_q == W_SEND) && bus.wready;
  assign final_beat = (kind_q == REQ_INV) || last_beat;

  ace_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .BEATS(BEATS)) u_line (
    .clk       (clk),
    .reset     (reset),
    .load      (accept && write_req),
    .load_line (wb_line),
    .fill_we   (r_hs && (kind_q == REQ_READ)),
    .fill_data (bus.rdata),
    .clr       (((state_q == AR_SEND) && bus.arready) || ((state_q == AW_SEND) && bus.awready)),
    .adv       (r_hs || w_hs),
    .line      (fill_line),
    .beat_data (beat_data),
    .beat      (beat),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      kind_q   <= REQ_READ;
      addr_q   <= '0;
      err_q    <= 1'b0;
      shared_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= req_addr;
        err_q  <= 1'b0;
        kind_q <= write_req ? REQ_WRITE : (invalid_req ? REQ_INV : REQ_READ);
      end
      // rlast is only flagged, never trusted to end the burst
      if (r_hs) begin
        if (resp_is_err(bus.rresp[1:0]) || (bus.rlast != final_beat))
          err_q <= 1'b1;
        if (final_beat && (kind_q == REQ_READ))
          shared_q <= bus.rresp[3];
      end
      if ((state_q == B_WAIT) && bus.bvalid && resp_is_err(bus.bresp))
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (write_req)                   state_d = AW_SEND;
               else if (invalid_req || read_req) state_d = AR_SEND;
      AR_SEND: if (bus.arready)                 state_d = R_RECV;
      R_RECV:  if (bus.rvalid && final_beat)    state_d = DONE;
      AW_SEND: if (bus.awready)                 state_d = W_SEND;
      W_SEND:  if (bus.wready && last_beat)     state_d = B_WAIT;
      B_WAIT:  if (bus.bvalid)                  state_d = DONE;
      DONE:                                     state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  assign bus.arvalid = (state_q == AR_SEND);
  assign bus.araddr  = addr_q;
  assign bus.arlen   = (kind_q == REQ_INV) ? 8'd0 : 8'(BEATS - 1);
  assign bus.arsnoop = (kind_q == REQ_INV) ? ARSNOOP_CLEANUNIQUE : ARSNOOP_READSHARED;
  assign bus.rready  = (state_q == R_RECV);
  assign bus.rack    = (state_q == DONE) && (kind_q != REQ_WRITE);
  assign bus.awvalid = (state_q == AW_SEND);
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = 8'(BEATS - 1);
  assign bus.awsnoop = AWSNOOP_WRITEBACK;
  assign bus.wvalid  = (state_q == W_SEND);
  assign bus.wdata   = beat_data;
  assign bus.wlast   = (state_q == W_SEND) && last_beat;
  assign bus.bready  = (state_q == B_WAIT);
  assign bus.wack    = (state_q == DONE) && (kind_q == REQ_WRITE);

  assign ace_ready   = (state_q == DONE);
  assign resp_err    = (state_q == DONE) && err_q;
  assign fill_shared = shared_q;
endmodule
